// File: rtl/minsoc_reset_manager.sv
// Reset sequencer: syncs PLL lock and reset button, debounces the button, takes software requests,
// then releases a stretched bus reset followed by the CPU reset. All outputs are registered from next state.
module minsoc_reset_manager #(
  parameter int unsigned STRETCH_CYCLES  = 16,
  parameter int unsigned CPU_DELAY       = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 8,
  parameter bit          BTN_ACTIVE_LOW  = 1'b1,
  parameter bit          USE_LOCKED      = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       locked_i,
  input  logic       btn_rst_i,
  input  logic       sw_rst_i,
  output logic       wb_rst_o,
  output logic       cpu_rst_o,
  output logic       ready_o,
  output logic [1:0] rst_cause_o
);

  localparam int unsigned MAX_SD  = (STRETCH_CYCLES > CPU_DELAY) ? STRETCH_CYCLES : CPU_DELAY;
  localparam int unsigned MAX_CNT = (MAX_SD > DEBOUNCE_CYCLES) ? MAX_SD : DEBOUNCE_CYCLES;
  localparam int unsigned CW      = $clog2(MAX_CNT + 1);

  localparam logic [CW-1:0] STRETCH_LAST = CW'(STRETCH_CYCLES - 1);
  localparam logic [CW-1:0] CPU_LAST     = CW'(CPU_DELAY - 1);
  localparam logic [CW-1:0] DEB_FULL     = CW'(DEBOUNCE_CYCLES);
  localparam logic          BTN_IDLE     = BTN_ACTIVE_LOW;

  localparam logic [2:0] S_HOLD      = 3'd0;
  localparam logic [2:0] S_WAIT_LOCK = 3'd1;
  localparam logic [2:0] S_STRETCH   = 3'd2;
  localparam logic [2:0] S_CPU_HOLD  = 3'd3;
  localparam logic [2:0] S_RUN       = 3'd4;

  logic [1:0]    lock_sync_q, btn_sync_q;
  logic          lock_prev_q;
  logic [CW-1:0] deb_cnt_q, deb_cnt_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    state_q, state_d;
  logic [1:0]    cause_q, cause_d;
  logic          wb_rst_q, wb_rst_d;
  logic          cpu_rst_q, cpu_rst_d;
  logic          ready_q, ready_d;

  logic lock_s, btn_act, btn_req, lock_lost;

  always_comb begin
    lock_s  = USE_LOCKED ? lock_sync_q[1] : 1'b1;
    btn_act = btn_sync_q[1] ^ BTN_IDLE;
    btn_req = (deb_cnt_q == DEB_FULL);
    // While waiting for lock, only a fresh drop counts as a loss, so a POR with lock still low keeps cause 00.
    lock_lost = ~lock_s & ((state_q != S_WAIT_LOCK) | lock_prev_q);

    if (!btn_act)     deb_cnt_d = '0;
    else if (btn_req) deb_cnt_d = deb_cnt_q;
    else              deb_cnt_d = deb_cnt_q + CW'(1);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cause_d = cause_q;
    if (state_q == S_HOLD) begin
      state_d = S_WAIT_LOCK;
      cnt_d   = '0;
    end else if (lock_lost) begin
      state_d = S_WAIT_LOCK;
      cnt_d   = '0;
      cause_d = 2'b01;
    end else if (btn_req) begin
      state_d = S_WAIT_LOCK;
      cnt_d   = '0;
      cause_d = 2'b10;
    end else if (sw_rst_i && (state_q != S_WAIT_LOCK)) begin
      state_d = S_STRETCH;
      cnt_d   = '0;
      cause_d = 2'b11;
    end else begin
      case (state_q)
        S_WAIT_LOCK: begin
          if (lock_s) begin
            state_d = S_STRETCH;
            cnt_d   = '0;
          end
        end
        S_STRETCH: begin
          if (cnt_q == STRETCH_LAST) begin
            state_d = S_CPU_HOLD;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_CPU_HOLD: begin
          if (cnt_q == CPU_LAST) begin
            state_d = S_RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_RUN: begin
        end
        default: begin
          state_d = S_HOLD;
          cnt_d   = '0;
        end
      endcase
    end

    wb_rst_d  = (state_d == S_HOLD) || (state_d == S_WAIT_LOCK) || (state_d == S_STRETCH);
    cpu_rst_d = (state_d != S_RUN);
    ready_d   = (state_d == S_RUN);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      lock_sync_q <= 2'b00;
      lock_prev_q <= 1'b0;
      btn_sync_q  <= {2{BTN_IDLE}};
      deb_cnt_q   <= '0;
      cnt_q       <= '0;
      state_q     <= S_HOLD;
      cause_q     <= 2'b00;
      wb_rst_q    <= 1'b1;
      cpu_rst_q   <= 1'b1;
      ready_q     <= 1'b0;
    end else begin
      lock_sync_q <= {lock_sync_q[0], locked_i};
      lock_prev_q <= lock_s;
      btn_sync_q  <= {btn_sync_q[0], btn_rst_i};
      deb_cnt_q   <= deb_cnt_d;
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      cause_q     <= cause_d;
      wb_rst_q    <= wb_rst_d;
      cpu_rst_q   <= cpu_rst_d;
      ready_q     <= ready_d;
    end
  end

  assign wb_rst_o    = wb_rst_q;
  assign cpu_rst_o   = cpu_rst_q;
  assign ready_o     = ready_q;
  assign rst_cause_o = cause_q;

endmodule
